sparc_ifu_thrsched: RTL and testbench

// - Schedules the NTHR per-thread thread-state FSMs onto the single IFU fetch pipe.
// - Decodes each thread's state and picks the next thread by round robin. Non-speculative RDY threads beat SPEC_RDY threads.
// - Drives each FSM's schedule and switch_out inputs.
// - Forces a switch after QUANTUM run cycles when another thread is RDY.

---
 rtl/sparc_ifu_thrsched_pkg.sv | 27 ++
 rtl/sparc_ifu_rr4.sv | 28 ++
 rtl/sparc_ifu_thrsched.sv | 127 ++++++++++++
 tb/tb_sparc_ifu_thrsched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared thread-FSM state codes and scheduler decision types for the IFU thread scheduler.
// The state codes mirror the ifu.tmp.h header and must stay bit-identical to it.
package sparc_ifu_thrsched_pkg;

    localparam int IFU_NTHR = 4;

    localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
    localparam logic [4:0] THRFSM_HALT     = 5'b00010;
    localparam logic [4:0] THRFSM_RDY      = 5'b11001;
    localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
    localparam logic [4:0] THRFSM_RUN      = 5'b00101;
    localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;
    localparam logic [4:0] THRFSM_WAIT     = 5'b00001;

    // Kind of decision taken in a cycle; exported registered for debug.
    typedef enum logic [1:0] {
        DEC_BLOCK  = 2'd0,
        DEC_PICK   = 2'd1,
        DEC_EXPIRE = 2'd2,
        DEC_RUN    = 2'd3
    } dec_e;

    function automatic logic [4:0] thr_code(input logic [5*IFU_NTHR-1:0] v, input int t);
        return v[5*t +: 5];
    endfunction

endpackage

// File: rtl/sparc_ifu_rr4.sv
// Combinational 4-way round-robin picker: grants the first requester after the
// one-hot pointer position, wrapping 3 -> 0.
module sparc_ifu_rr4 (
    input  logic [3:0] i_req,
    input  logic [3:0] i_ptr,
    output logic [3:0] o_gnt
);

    logic [1:0] w_base;

    always_comb begin
        w_base = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (i_ptr[i]) w_base = 2'(i);
        end
    end

    // Walk from lowest to highest priority so the nearest requester wins last.
    always_comb begin
        logic [1:0] w_idx;
        o_gnt = '0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = w_base + 2'(k);
            if (i_req[w_idx]) o_gnt = 4'b0001 << w_idx;
        end
    end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// Thread scheduler for the single IFU fetch pipe: picks the next thread by round
// robin (RDY before SPEC_RDY), pulses schedule/switch_out and forces quantum switches.
module sparc_ifu_thrsched
    import sparc_ifu_thrsched_pkg::*;
#(
    parameter int NTHR    = IFU_NTHR,
    parameter int QUANTUM = 16,
    parameter int QW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5*NTHR-1:0] i_thr_state,
    input  logic            i_pipe_hold,
    output logic [NTHR-1:0] o_thr_schedule,
    output logic [NTHR-1:0] o_thr_switch_out,
    output logic [NTHR-1:0] o_cur_thr,
    output logic            o_cur_spec,
    output logic [QW-1:0]   o_dbg_qcnt,
    output logic [NTHR-1:0] o_dbg_rr_ptr,
    output dec_e            o_dbg_dec
);

    logic [NTHR-1:0] r_sched, r_swout, r_cur, r_rr_ptr;
    logic            r_spec;
    logic [QW-1:0]   r_qcnt;
    dec_e            r_dec;

    logic [NTHR-1:0] w_rdy, w_srdy, w_run, w_spec_run;
    logic [NTHR-1:0] w_rdy_x, w_srdy_x, w_gnt_rdy, w_gnt_srdy, w_cand;
    logic            w_cand_spec, w_blocked, w_cur_run, w_cur_srun, w_qmax;
    dec_e            w_dec;

    always_comb begin
        w_rdy      = '0;
        w_srdy     = '0;
        w_run      = '0;
        w_spec_run = '0;
        for (int t = 0; t < NTHR; t++) begin
            w_rdy[t]      = (thr_code(i_thr_state, t) == THRFSM_RDY);
            w_srdy[t]     = (thr_code(i_thr_state, t) == THRFSM_SPEC_RDY);
            w_spec_run[t] = (thr_code(i_thr_state, t) == THRFSM_SPEC_RUN);
            w_run[t]      = (thr_code(i_thr_state, t) == THRFSM_RUN) || w_spec_run[t];
        end
    end

    // The owning thread never competes against itself.
    assign w_rdy_x  = w_rdy  & ~r_cur;
    assign w_srdy_x = w_srdy & ~r_cur;

    sparc_ifu_rr4 u_rr_rdy (
        .i_req (w_rdy_x),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt_rdy)
    );

    sparc_ifu_rr4 u_rr_srdy (
        .i_req (w_srdy_x),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt_srdy)
    );

    assign w_cand      = (|w_rdy_x) ? w_gnt_rdy : w_gnt_srdy;
    assign w_cand_spec = ~(|w_rdy_x) & (|w_srdy_x);

    // FSM inputs are one cycle stale while a pulse is out, so no decision then.
    assign w_blocked  = (|r_sched) | (|r_swout) | i_pipe_hold;
    assign w_cur_run  = |(r_cur & w_run);
    assign w_cur_srun = |(r_cur & w_spec_run);
    assign w_qmax     = (r_qcnt == QW'(QUANTUM - 1));

    always_comb begin
        if (w_blocked)                 w_dec = DEC_BLOCK;
        else if (!w_cur_run)           w_dec = DEC_PICK;
        else if (w_qmax && |w_rdy_x)   w_dec = DEC_EXPIRE;
        else                           w_dec = DEC_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sched  <= '0;
            r_swout  <= '0;
            r_cur    <= '0;
            r_spec   <= 1'b0;
            r_qcnt   <= '0;
            r_rr_ptr <= NTHR'(1) << (NTHR - 1);
            r_dec    <= DEC_BLOCK;
        end else begin
            r_sched <= '0;
            r_swout <= '0;
            r_dec   <= w_dec;
            case (w_dec)
                DEC_PICK: begin
                    // Idle, or the owner already left RUN: take the candidate back-to-back.
                    r_cur  <= w_cand;
                    r_spec <= w_cand_spec;
                    r_qcnt <= '0;
                    if (|w_cand) begin
                        r_sched  <= w_cand;
                        r_rr_ptr <= w_cand;
                    end
                end
                DEC_EXPIRE: begin
                    r_swout  <= r_cur;
                    r_sched  <= w_gnt_rdy;
                    r_cur    <= w_gnt_rdy;
                    r_rr_ptr <= w_gnt_rdy;
                    r_qcnt   <= '0;
                    r_spec   <= 1'b0;
                end
                DEC_RUN: begin
                    if (!w_qmax) r_qcnt <= r_qcnt + 1'b1;
                    r_spec <= w_cur_srun;
                end
                default: ;
            endcase
        end
    end

    assign o_thr_schedule   = r_sched;
    assign o_thr_switch_out = r_swout;
    assign o_cur_thr        = r_cur;
    assign o_cur_spec       = r_spec;
    assign o_dbg_qcnt       = r_qcnt;
    assign o_dbg_rr_ptr     = r_rr_ptr;
    assign o_dbg_dec        = r_dec;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Bench for sparc_ifu_thrsched: directed vector table, corner-case sequences and
// randomized thread-state traffic checked against an index-based reference model.
module tb_sparc_ifu_thrsched;
    import sparc_ifu_thrsched_pkg::*;

    localparam int QUANTUM = 16;
    localparam int QW      = 8;

    localparam logic [4:0] C_I = THRFSM_IDLE;
    localparam logic [4:0] C_R = THRFSM_RDY;
    localparam logic [4:0] C_S = THRFSM_SPEC_RDY;
    localparam logic [4:0] C_U = THRFSM_RUN;
    localparam logic [4:0] C_P = THRFSM_SPEC_RUN;
    localparam logic [4:0] C_W = THRFSM_WAIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] thr_state = '0;
    logic        pipe_hold = 1'b0;
    logic [3:0]  thr_schedule, thr_switch_out, cur_thr, dbg_rr_ptr;
    logic        cur_spec;
    logic [QW-1:0] dbg_qcnt;
    dec_e        dbg_dec;

    always #5 clk = ~clk;

    sparc_ifu_thrsched #(.NTHR(4), .QUANTUM(QUANTUM), .QW(QW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_thr_state      (thr_state),
        .i_pipe_hold      (pipe_hold),
        .o_thr_schedule   (thr_schedule),
        .o_thr_switch_out (thr_switch_out),
        .o_cur_thr        (cur_thr),
        .o_cur_spec       (cur_spec),
        .o_dbg_qcnt       (dbg_qcnt),
        .o_dbg_rr_ptr     (dbg_rr_ptr),
        .o_dbg_dec        (dbg_dec)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner as an index (-1 = idle), pointer as an index.
    int          m_cur, m_ptr, m_q;
    bit          m_spec;
    logic [3:0]  m_sched, m_swout;
    logic [4:0]  st[4];
    logic [20:0] exp_q[$];

    typedef struct {
        logic [4:0] s0, s1, s2, s3;
        bit         hold;
        logic [3:0] sched, swout, cur;
        bit         spec;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [4:0] code);
        for (int k = 1; k <= 4; k++) begin
            int t;
            t = (m_ptr + k) % 4;
            if (t != m_cur && st[t] == code) return t;
        end
        return -1;
    endfunction

    function automatic bit is_run(input logic [4:0] c);
        return (c == THRFSM_RUN) || (c == THRFSM_SPEC_RUN);
    endfunction

    function automatic logic [3:0] idx_vec(input int i);
        return (i < 0) ? 4'b0000 : 4'(1 << i);
    endfunction

    task automatic model_reset();
        m_cur = -1; m_ptr = 3; m_q = 0; m_spec = 1'b0;
        m_sched = '0; m_swout = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int cr, cs, cand;
        bit blocked;
        blocked = (m_sched != 0) || (m_swout != 0) || pipe_hold;
        m_sched = '0;
        m_swout = '0;
        if (!blocked) begin
            cr = pick(THRFSM_RDY);
            cs = pick(THRFSM_SPEC_RDY);
            cand = (cr >= 0) ? cr : cs;
            if (m_cur < 0 || !is_run(st[m_cur])) begin
                m_cur = cand;
                m_spec = (cr < 0) && (cs >= 0);
                m_q = 0;
                if (cand >= 0) begin
                    m_sched = idx_vec(cand);
                    m_ptr = cand;
                end
            end else if (m_q == QUANTUM - 1 && cr >= 0) begin
                m_swout = idx_vec(m_cur);
                m_sched = idx_vec(cr);
                m_cur = cr; m_ptr = cr; m_q = 0; m_spec = 1'b0;
            end else begin
                if (m_q < QUANTUM - 1) m_q++;
                m_spec = (st[m_cur] == THRFSM_SPEC_RUN);
            end
        end
        exp_q.push_back({m_sched, m_swout, idx_vec(m_cur), m_spec, 8'(m_q)});
    endtask

    task automatic compare();
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("sched",  thr_schedule,   e[20:17]);
        check("swout",  thr_switch_out, e[16:13]);
        check("cur",    cur_thr,        e[12:9]);
        check("spec",   cur_spec,       e[8]);
        check("qcnt",   dbg_qcnt,       e[7:0]);
        check("sched_onehot", $onehot0(thr_schedule),   1);
        check("swout_onehot", $onehot0(thr_switch_out), 1);
        check("cur_onehot",   $onehot0(cur_thr),        1);
    endtask

    // Called at a negedge: apply one cycle of inputs, then compare after the posedge.
    task automatic step(input logic [4:0] s0, s1, s2, s3, input bit hold);
        st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
        thr_state = {s3, s2, s1, s0};
        pipe_hold = hold;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        thr_state = '0;
        pipe_hold = 1'b0;
        for (int t = 0; t < 4; t++) st[t] = THRFSM_IDLE;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_sched", thr_schedule, 0);
        check("rst_swout", thr_switch_out, 0);
        check("rst_cur",   cur_thr, 0);
        check("rst_spec",  cur_spec, 0);
        check("rst_qcnt",  dbg_qcnt, 0);
        check("rst_rrptr", dbg_rr_ptr, 4'b1000);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [4:0] s0, s1, s2, s3, input bit hold,
                                input logic [3:0] sched, swout, cur, input bit spec);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.hold = hold;
        v.sched = sched; v.swout = swout; v.cur = cur; v.spec = spec;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] codes[8];
        logic [4:0] ns[4];
        int cnt;
        bit seen;

        codes[0] = THRFSM_IDLE;     codes[1] = THRFSM_HALT;
        codes[2] = THRFSM_RDY;      codes[3] = THRFSM_SPEC_RDY;
        codes[4] = THRFSM_RUN;      codes[5] = THRFSM_SPEC_RUN;
        codes[6] = THRFSM_WAIT;     codes[7] = 5'b11111;

        tbl[0]  = mk(C_I, C_R, C_I, C_I, 0, 4'b0010, 4'b0000, 4'b0010, 0);
        tbl[1]  = mk(C_I, C_R, C_I, C_I, 0, 4'b0000, 4'b0000, 4'b0010, 0);
        tbl[2]  = mk(C_I, C_U, C_I, C_I, 0, 4'b0000, 4'b0000, 4'b0010, 0);
        tbl[3]  = mk(C_R, C_U, C_I, C_S, 0, 4'b0000, 4'b0000, 4'b0010, 0);
        tbl[4]  = mk(C_R, C_W, C_I, C_S, 0, 4'b0001, 4'b0000, 4'b0001, 0);
        tbl[5]  = mk(C_R, C_W, C_I, C_S, 0, 4'b0000, 4'b0000, 4'b0001, 0);
        tbl[6]  = mk(C_U, C_W, C_I, C_S, 0, 4'b0000, 4'b0000, 4'b0001, 0);
        tbl[7]  = mk(C_W, C_I, C_I, C_S, 0, 4'b1000, 4'b0000, 4'b1000, 1);
        tbl[8]  = mk(C_W, C_I, C_I, C_S, 0, 4'b0000, 4'b0000, 4'b1000, 1);
        tbl[9]  = mk(C_W, C_I, C_I, C_P, 0, 4'b0000, 4'b0000, 4'b1000, 1);
        tbl[10] = mk(C_W, C_I, C_I, C_U, 0, 4'b0000, 4'b0000, 4'b1000, 0);
        tbl[11] = mk(C_R, C_S, C_I, C_U, 1, 4'b0000, 4'b0000, 4'b1000, 0);
        tbl[12] = mk(C_R, C_S, C_I, C_U, 0, 4'b0000, 4'b0000, 4'b1000, 0);
        tbl[13] = mk(C_R, C_S, C_I, C_W, 0, 4'b0001, 4'b0000, 4'b0001, 0);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].hold);
            check("tbl_sched", thr_schedule,   tbl[i].sched);
            check("tbl_swout", thr_switch_out, tbl[i].swout);
            check("tbl_cur",   cur_thr,        tbl[i].cur);
            check("tbl_spec",  cur_spec,       tbl[i].spec);
        end

        // Quantum expiry and round-robin wrap.
        do_reset();
        step(C_I, C_R, C_I, C_I, 0);
        check("q_first_sched", thr_schedule, 4'b0010);
        step(C_I, C_R, C_I, C_I, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step(C_I, C_U, C_I, C_I, 0);
            if (thr_switch_out != 0) seen = 1;
        end
        check("q_no_swout_alone", seen, 0);
        check("q_saturated", dbg_qcnt, QUANTUM - 1);
        step(C_R, C_U, C_R, C_I, 0);
        check("q_exp1_swout", thr_switch_out, 4'b0010);
        check("q_exp1_sched", thr_schedule,   4'b0100);
        step(C_R, C_R, C_R, C_I, 0);
        cnt = 0; seen = 0;
        while (!seen && cnt < 40) begin
            step(C_R, C_R, C_U, C_I, 0);
            cnt++;
            if (thr_switch_out != 0) seen = 1;
        end
        check("q_exp2_seen",  seen, 1);
        check("q_exp2_cycle", cnt, 16);
        check("q_exp2_swout", thr_switch_out, 4'b0100);
        check("q_exp2_sched", thr_schedule,   4'b0001);

        // Owner drops to WAIT, only a SPEC_RDY thread available.
        do_reset();
        step(C_I, C_I, C_R, C_I, 0);
        check("sp_sched2", thr_schedule, 4'b0100);
        step(C_I, C_I, C_R, C_I, 0);
        step(C_I, C_I, C_U, C_S, 0);
        step(C_I, C_I, C_W, C_S, 0);
        check("sp_sched3", thr_schedule, 4'b1000);
        check("sp_swout",  thr_switch_out, 4'b0000);
        check("sp_spec1",  cur_spec, 1);
        step(C_I, C_I, C_W, C_S, 0);
        step(C_I, C_I, C_W, C_P, 0);
        check("sp_spec_run", cur_spec, 1);
        step(C_I, C_I, C_W, C_U, 0);
        check("sp_spec_drop", cur_spec, 0);

        // RDY beats SPEC_RDY from idle.
        do_reset();
        step(C_R, C_S, C_I, C_I, 0);
        check("pref_sched", thr_schedule, 4'b0001);
        check("pref_spec",  cur_spec, 0);
        step(C_R, C_S, C_I, C_I, 0);
        step(C_U, C_S, C_I, C_I, 0);
        check("pref_waits", thr_schedule, 4'b0000);

        // pipe_hold over an expiry condition.
        do_reset();
        step(C_R, C_I, C_I, C_I, 0);
        step(C_R, C_I, C_I, C_I, 0);
        for (int i = 0; i < 15; i++) step(C_U, C_I, C_I, C_I, 0);
        for (int i = 0; i < 5; i++) begin
            step(C_U, C_R, C_I, C_I, 1);
            check("hold_no_sched", thr_schedule, 4'b0000);
            check("hold_no_swout", thr_switch_out, 4'b0000);
            check("hold_qcnt", dbg_qcnt, QUANTUM - 1);
        end
        step(C_U, C_R, C_I, C_I, 0);
        check("hold_rel_swout", thr_switch_out, 4'b0001);
        check("hold_rel_sched", thr_schedule,   4'b0010);

        // Asynchronous reset while a schedule pulse is out.
        do_reset();
        step(C_I, C_I, C_R, C_I, 0);
        check("mid_pulse", thr_schedule, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sched", thr_schedule, 0);
        check("mid_rst_cur",   cur_thr, 0);
        check("mid_rst_rrptr", dbg_rr_ptr, 4'b1000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(C_R, C_R, C_R, C_R, 0);
        check("mid_first_pick", thr_schedule, 4'b0001);

        // Random traffic: threads react to the model's pulses, plus random state churn.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int t = 0; t < 4; t++) begin
                ns[t] = st[t];
                if (m_sched[t])
                    ns[t] = (st[t] == THRFSM_SPEC_RDY) ? THRFSM_SPEC_RUN : THRFSM_RUN;
                else if (m_swout[t])
                    ns[t] = THRFSM_RDY;
                else if ($urandom_range(0, 15) == 0)
                    ns[t] = codes[$urandom_range(0, 7)];
            end
            step(ns[0], ns[1], ns[2], ns[3], ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
